// File: rtl/coinc_trig_gen.sv
// Coincidence trigger: stretches masked channel edges, counts active channels, fires when count > thresh.
// Latency: edge sampled at clock E gives trig_o in the cycle after clock E+4 (2 sync, stretch, popcount, compare).
// Backpressure: none; trig_o is a free-running single-cycle pulse, holdoff provides dead time.
module coinc_trig_gen #(
    parameter int NCHAN     = 24,
    parameter int WIN_BITS  = 8,
    parameter int HOLD_BITS = 16,
    parameter int CNT_BITS  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [NCHAN-1:0]     trig_i,
    input  logic [NCHAN-1:0]     mask_i,
    input  logic [WIN_BITS-1:0]  window_i,
    input  logic [CNT_BITS-1:0]  thresh_i,
    input  logic [HOLD_BITS-1:0] holdoff_i,
    input  logic                 inhibit_i,
    output logic                 trig_o,
    output logic [NCHAN-1:0]     trig_chans_o,
    output logic [CNT_BITS-1:0]  trig_count_o,
    output logic                 busy_o,
    output logic [31:0]          ntrig_o,
    output logic [31:0]          ninhib_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // State declarations
    // ---------------------------------------------------------------
    state_t                       state_q, state_d;

    logic [NCHAN-1:0]             sync1_q, sync1_d;
    logic [NCHAN-1:0]             sync2_q, sync2_d;

    logic [NCHAN-1:0][WIN_BITS:0] str_q, str_d;

    logic [NCHAN-1:0]             map_q, map_d;
    logic [CNT_BITS-1:0]          cnt_q, cnt_d;

    logic                         coinc_q, coinc_d;
    logic                         coinc_prev_q, coinc_prev_d;
    logic [NCHAN-1:0]             map2_q, map2_d;
    logic [CNT_BITS-1:0]          cnt2_q, cnt2_d;

    logic [HOLD_BITS-1:0]         hold_q, hold_d;
    logic                         trig_q, trig_d;
    logic [NCHAN-1:0]             chans_q, chans_d;
    logic [CNT_BITS-1:0]          count_q, count_d;
    logic [31:0]                  ntrig_q, ntrig_d;
    logic [31:0]                  ninhib_q, ninhib_d;

    // Combinational helpers
    logic [NCHAN-1:0]             chan_edge;
    logic [NCHAN-1:0]             active;
    logic [CNT_BITS-1:0]          pop_cnt;
    logic [WIN_BITS:0]            win_load;
    logic                         armed;

    assign armed    = (state_q == ST_ARMED);
    assign win_load = (WIN_BITS+1)'(window_i) + (WIN_BITS+1)'(1);

    // Two-flop edge pipeline on the raw inputs; an edge is a masked 0->1 transition.
    always_comb begin
        sync1_d   = trig_i;
        sync2_d   = sync1_q;
        chan_edge = sync1_q & ~sync2_q & mask_i;
    end

    // Per-channel stretch counters; only run while ARMED, otherwise held at zero.
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            str_d[i] = str_q[i];
            if (!armed) begin
                str_d[i] = '0;
            end else if (chan_edge[i]) begin
                str_d[i] = win_load;
            end else if (str_q[i] != '0) begin
                str_d[i] = str_q[i] - (WIN_BITS+1)'(1);
            end
        end
    end

    // Active map and its population count.
    always_comb begin
        pop_cnt = '0;
        active  = '0;
        for (int i = 0; i < NCHAN; i++) begin
            active[i] = (str_q[i] != '0);
            pop_cnt   = pop_cnt + CNT_BITS'(active[i]);
        end
    end

    // Count/compare pipeline; flushed whenever not ARMED so stale hits never survive holdoff.
    always_comb begin
        map_d        = '0;
        cnt_d        = '0;
        coinc_d      = 1'b0;
        coinc_prev_d = 1'b0;
        map2_d       = '0;
        cnt2_d       = '0;
        if (armed) begin
            map_d        = active;
            cnt_d        = pop_cnt;
            coinc_d      = (cnt_q > thresh_i);
            coinc_prev_d = coinc_q;
            map2_d       = map_q;
            cnt2_d       = cnt_q;
        end
    end

    // Trigger FSM: next state, trigger issue, latching and counters.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        trig_d   = 1'b0;
        chans_d  = chans_q;
        count_d  = count_q;
        ntrig_d  = ntrig_q;
        ninhib_d = ninhib_q;
        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (coinc_q) begin
                    if (!inhibit_i) begin
                        trig_d  = 1'b1;
                        chans_d = map2_q;
                        count_d = cnt2_q;
                        ntrig_d = ntrig_q + 32'd1;
                        hold_d  = holdoff_i;
                        state_d = ST_HOLDOFF;
                    end else if (!coinc_prev_q) begin
                        // Count each suppressed coincidence once, on its rising edge.
                        ninhib_d = ninhib_q + 32'd1;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (hold_q == '0) begin
                    state_d = ST_ARMED;
                end else begin
                    hold_d = hold_q - HOLD_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Input synchronisers and stretch counters.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            str_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            str_q   <= str_d;
        end
    end

    // Popcount and compare pipeline registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            map_q        <= '0;
            cnt_q        <= '0;
            coinc_q      <= 1'b0;
            coinc_prev_q <= 1'b0;
            map2_q       <= '0;
            cnt2_q       <= '0;
        end else begin
            map_q        <= map_d;
            cnt_q        <= cnt_d;
            coinc_q      <= coinc_d;
            coinc_prev_q <= coinc_prev_d;
            map2_q       <= map2_d;
            cnt2_q       <= cnt2_d;
        end
    end

    // FSM state, holdoff timer, latched trigger info and statistics counters.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            hold_q   <= '0;
            trig_q   <= 1'b0;
            chans_q  <= '0;
            count_q  <= '0;
            ntrig_q  <= '0;
            ninhib_q <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            trig_q   <= trig_d;
            chans_q  <= chans_d;
            count_q  <= count_d;
            ntrig_q  <= ntrig_d;
            ninhib_q <= ninhib_d;
        end
    end

    assign trig_o       = trig_q;
    assign trig_chans_o = chans_q;
    assign trig_count_o = count_q;
    assign busy_o       = (state_q == ST_HOLDOFF);
    assign ntrig_o      = ntrig_q;
    assign ninhib_o     = ninhib_q;

endmodule

// File: tb/tb_coinc_trig_gen.sv
// Bench for coinc_trig_gen: directed pulse patterns, expected triggers queued, monitor compares on trig_o.
// Latency: each expected trigger carries the exact cycle it must appear in.
// Backpressure: none; the monitor samples every falling clock edge.
module tb_coinc_trig_gen;

    localparam int NCHAN = 24;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic [23:0] trig_i;
    logic [23:0] mask_i;
    logic [7:0]  window_i;
    logic [4:0]  thresh_i;
    logic [15:0] holdoff_i;
    logic        inhibit_i;
    logic        trig_o;
    logic [23:0] trig_chans_o;
    logic [4:0]  trig_count_o;
    logic        busy_o;
    logic [31:0] ntrig_o;
    logic [31:0] ninhib_o;

    coinc_trig_gen #(
        .NCHAN(24), .WIN_BITS(8), .HOLD_BITS(16), .CNT_BITS(5)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .trig_i(trig_i),
        .mask_i(mask_i), .window_i(window_i), .thresh_i(thresh_i),
        .holdoff_i(holdoff_i), .inhibit_i(inhibit_i), .trig_o(trig_o),
        .trig_chans_o(trig_chans_o), .trig_count_o(trig_count_o),
        .busy_o(busy_o), .ntrig_o(ntrig_o), .ninhib_o(ninhib_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [23:0] chans;
        logic [4:0]  cnt;
        logic [31:0] ntrig;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   busy_run = 0;
    int   last_busy = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pop an expected trigger whenever trig_o is seen, and track busy run length.
    always @(negedge clk_i) begin
        if (trig_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_trig", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("trig_cycle", cyc, e.cyc);
                chk("trig_chans", trig_chans_o, e.chans);
                chk("trig_count", trig_count_o, e.cnt);
                chk("ntrig_at_trig", ntrig_o, e.ntrig);
            end
        end
        if (busy_o === 1'b1) begin
            busy_run++;
        end else if (busy_run != 0) begin
            last_busy = busy_run;
            busy_run  = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // One-cycle pulse; e is the posedge count at which the first sync flop samples it.
    task automatic pulse(input logic [23:0] bits, output int e);
        trig_i = bits;
        e = cyc + 1;
        @(negedge clk_i);
        trig_i = '0;
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        trig_i  = '0;
        tick(2);
        rst_n_i = 1'b1;
        tick(3);
    endtask

    task automatic push_exp(input int c, input logic [23:0] ch, input logic [4:0] n, input logic [31:0] nt);
        exp_t e;
        e.cyc = c; e.chans = ch; e.cnt = n; e.ntrig = nt;
        exp_q.push_back(e);
    endtask

    initial begin
        int e;
        rst_n_i = 1'b0; en_i = 1'b1; trig_i = '0; mask_i = 24'hFFFFFF;
        window_i = 8'd73; thresh_i = 5'd2; holdoff_i = 16'd10; inhibit_i = 1'b0;
        tick(2);

        // Reset state
        chk("rst_trig", trig_o, 0);
        chk("rst_chans", trig_chans_o, 0);
        chk("rst_count", trig_count_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ntrig", ntrig_o, 0);
        chk("rst_ninhib", ninhib_o, 0);
        rst_n_i = 1'b1;
        tick(3);

        // Three channels spaced 10 cycles -> one trigger
        pulse(24'h000001, e); tick(9);
        pulse(24'h000002, e); tick(9);
        pulse(24'h000004, e);
        push_exp(e + 4, 24'h000007, 5'd3, 32'd1);
        tick(40);
        chk("basic_ntrig", ntrig_o, 1);

        // ch2 80 cycles after ch0 -> window of ch0 has expired
        do_reset();
        pulse(24'h000001, e); tick(9);
        pulse(24'h000002, e); tick(69);
        pulse(24'h000004, e);
        tick(20);
        chk("expired_ntrig", ntrig_o, 0);

        // ch2 masked out; ch3 completes the coincidence
        do_reset();
        mask_i = 24'hFFFFFB;
        pulse(24'h000001, e); tick(9);
        pulse(24'h000002, e); tick(9);
        pulse(24'h000004, e); tick(9);
        chk("masked_no_trig", ntrig_o, 0);
        pulse(24'h000008, e);
        push_exp(e + 4, 24'h00000B, 5'd3, 32'd1);
        tick(30);
        chk("masked_ntrig", ntrig_o, 1);
        mask_i = 24'hFFFFFF;

        // Inhibited coincidence counted once, then a fresh one triggers
        do_reset();
        inhibit_i = 1'b1;
        pulse(24'h000007, e);
        tick(100);
        chk("inhib_ninhib", ninhib_o, 1);
        chk("inhib_ntrig", ntrig_o, 0);
        inhibit_i = 1'b0;
        tick(2);
        pulse(24'h000038, e);
        push_exp(e + 4, 24'h000038, 5'd3, 32'd1);
        tick(30);
        chk("post_inhib_ntrig", ntrig_o, 1);
        chk("post_inhib_ninhib", ninhib_o, 1);

        // Holdoff 100: second coincidence 50 cycles later is ignored
        do_reset();
        holdoff_i = 16'd100;
        pulse(24'h000007, e);
        push_exp(e + 4, 24'h000007, 5'd3, 32'd1);
        tick(49);
        pulse(24'h000038, e);
        tick(120);
        chk("holdoff_ntrig", ntrig_o, 1);
        chk("busy_len", last_busy, 101);

        // Reset for one cycle in the middle of holdoff
        pulse(24'h000007, e);
        push_exp(e + 4, 24'h000007, 5'd3, 32'd2);
        tick(20);
        chk("mid_hold_busy", busy_o, 1);
        rst_n_i = 1'b0;
        tick(1);
        rst_n_i = 1'b1;
        chk("abort_trig", trig_o, 0);
        chk("abort_chans", trig_chans_o, 0);
        chk("abort_count", trig_count_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_ntrig", ntrig_o, 0);
        chk("abort_ninhib", ninhib_o, 0);
        holdoff_i = 16'd10;
        tick(3);

        // Reset mid-window aborts the pending trigger
        pulse(24'h000007, e);
        rst_n_i = 1'b0;
        tick(1);
        rst_n_i = 1'b1;
        tick(20);
        chk("win_abort_ntrig", ntrig_o, 0);

        // thresh 0: any single masked edge triggers
        do_reset();
        thresh_i = 5'd0;
        pulse(24'h000020, e);
        push_exp(e + 4, 24'h000020, 5'd1, 32'd1);
        tick(30);

        // thresh = NCHAN never triggers, even with every channel
        do_reset();
        thresh_i = 5'd24;
        pulse(24'hFFFFFF, e);
        tick(20);
        chk("thresh_max_ntrig", ntrig_o, 0);

        // thresh = NCHAN-1 triggers only with every channel
        do_reset();
        thresh_i = 5'd23;
        pulse(24'hFFFFFF, e);
        push_exp(e + 4, 24'hFFFFFF, 5'd24, 32'd1);
        tick(30);

        tick(5);
        chk("missing_trig", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
